// File: rtl/alu_pkg.sv
// Shared constants and op encoding for the 20-bit ALU slice.
package alu_pkg;

  localparam int WORD_W = 20;
  localparam int HALF_W = WORD_W / 2;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_ADD  = 2'b01,
    OP_ADC  = 2'b10,
    OP_RSVD = 2'b11
  } alu_op_t;

endpackage : alu_pkg

// File: rtl/alu_adder20.sv
// Combinational 20-bit adder with half-word mode: upper operand bits are
// masked off and the carry is taken from bit 9 instead of bit 19.
module alu_adder20
  import alu_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  input  logic              mode,
  output logic [WORD_W-1:0] sum,
  output logic              cout
);

  logic [WORD_W-1:0] a_m;
  logic [WORD_W-1:0] b_m;
  logic [WORD_W:0]   raw;

  assign a_m = mode ? a : {{HALF_W{1'b0}}, a[HALF_W-1:0]};
  assign b_m = mode ? b : {{HALF_W{1'b0}}, b[HALF_W-1:0]};
  assign raw = {1'b0, a_m} + {1'b0, b_m} + {{WORD_W{1'b0}}, cin};

  // In half-word mode the carry out of bit 9 lands in raw[10]; clear it from the result.
  assign sum  = mode ? raw[WORD_W-1:0] : {{HALF_W{1'b0}}, raw[HALF_W-1:0]};
  assign cout = mode ? raw[WORD_W]     : raw[HALF_W];

endmodule : alu_adder20

// File: rtl/alu_add_and_unit.sv
// Registered ALU slice: AND / ADD / ADC in full- or half-word mode, with a
// held carry flag, zero detect and one-cycle latency.
module alu_add_and_unit
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [1:0]        op,
  input  logic              mode,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic [WORD_W-1:0] c,
  output logic              zero,
  output logic              carry,
  output logic              valid_out
);

  alu_op_t           op_e;
  logic              cin;
  logic [WORD_W-1:0] sum;
  logic              cout;
  logic [WORD_W-1:0] and_res;
  logic [WORD_W-1:0] result;
  logic              accept;

  assign op_e   = alu_op_t'(op);
  assign cin    = (op_e == OP_ADC) ? carry : 1'b0;
  assign accept = valid_in && (op_e != OP_RSVD);

  alu_adder20 u_adder (
    .a    (a),
    .b    (b),
    .cin  (cin),
    .mode (mode),
    .sum  (sum),
    .cout (cout)
  );

  assign and_res = mode ? (a & b) : {{HALF_W{1'b0}}, a[HALF_W-1:0] & b[HALF_W-1:0]};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    result = sum;
    if (op_e == OP_AND) result = and_res;
  end

  // NOTE: state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c         <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= accept;
      if (accept) begin
        c    <= result;
        // Upper half of result is already zero in half-word mode, so a full compare suffices.
        zero <= (result == '0);
        if (op_e != OP_AND) carry <= cout;
      end
    end
  end

endmodule : alu_add_and_unit

// File: tb/tb_alu_add_and_unit.sv
// Scoreboard bench for alu_add_and_unit: expected results are queued as ops
// are driven and compared when valid_out reports them.
module tb_alu_add_and_unit;
  import alu_pkg::*;

  typedef struct packed {
    logic [19:0] c;
    logic        zero;
    logic        carry;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [1:0]  op;
  logic        mode;
  logic [19:0] a, b;
  logic [19:0] c;
  logic        zero, carry, valid_out;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t exp_q[$];
  exp_t model;

  always #5 clk = ~clk;

  alu_add_and_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .op        (op),
    .mode      (mode),
    .a         (a),
    .b         (b),
    .c         (c),
    .zero      (zero),
    .carry     (carry),
    .valid_out (valid_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
  endtask

  // Reference behaviour written from the arithmetic definition, per op and mode.
  task automatic model_op(input logic [1:0] o, input logic m,
                          input logic [19:0] aa, input logic [19:0] bb);
    logic [20:0] s_full;
    logic [10:0] s_half;
    logic        ci;
    ci = (o == 2'b10) ? model.carry : 1'b0;
    if (o == 2'b00) begin
      model.c = m ? (aa & bb) : {10'd0, aa[9:0] & bb[9:0]};
    end else if (m) begin
      s_full      = aa + bb + ci;
      model.c     = s_full[19:0];
      model.carry = s_full[20];
    end else begin
      s_half      = aa[9:0] + bb[9:0] + ci;
      model.c     = {10'd0, s_half[9:0]};
      model.carry = s_half[10];
    end
    model.zero = (model.c == 20'd0);
  endtask

  task automatic step(input logic v, input logic [1:0] o, input logic m,
                      input logic [19:0] aa, input logic [19:0] bb);
    logic exp_vo;
    exp_t e;
    valid_in = v; op = o; mode = m; a = aa; b = bb;
    exp_vo = 1'b0;
    if (!rst_n) begin
      model = '0;
    end else if (v && o != 2'b11) begin
      model_op(o, m, aa, bb);
      exp_q.push_back(model);
      exp_vo = 1'b1;
    end
    @(posedge clk);
    #1;
    check("valid_out", valid_out, exp_vo);
    if (exp_vo) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_underflow", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("c", c, e.c);
        check("zero", zero, e.zero);
        check("carry", carry, e.carry);
      end
    end else begin
      check("c_hold", c, model.c);
      check("zero_hold", zero, model.zero);
      check("carry_hold", carry, model.carry);
    end
  endtask

  initial begin
    model = '0;
    rst_n = 1'b0;
    // Scenario 1: reset wins over a valid ADD.
    step(1'b1, 2'b01, 1'b1, 20'hFFFFF, 20'hFFFFF);
    step(1'b1, 2'b01, 1'b1, 20'hFFFFF, 20'hFFFFF);
    check("rst_c", c, 20'h00000);
    rst_n = 1'b1;

    // Scenario 2: full-word AND.
    step(1'b1, 2'b00, 1'b1, 20'hF0F0F, 20'h0FF0F);
    check("and1_c", c, 20'h00F0F);
    step(1'b1, 2'b00, 1'b1, 20'hAAAAA, 20'h55555);
    check("and2_zero", zero, 1'b1);

    // Scenarios 3-4: overflow, then ADC chained on the next cycle.
    step(1'b1, 2'b01, 1'b1, 20'hFFFFF, 20'h00001);
    check("ovf_carry", carry, 1'b1);
    step(1'b1, 2'b10, 1'b1, 20'h00010, 20'h00020);
    check("adc_c", c, 20'h00031);
    step(1'b1, 2'b01, 1'b1, 20'h00001, 20'h00002);
    check("add_c", c, 20'h00003);

    // Scenario 5: half-word ADD wraps; half-word AND keeps carry.
    step(1'b1, 2'b01, 1'b0, 20'hABCFF, 20'h12301);
    check("half_add_carry", carry, 1'b1);
    step(1'b1, 2'b00, 1'b0, 20'hFFC00, 20'hFFFFF);
    check("half_and_carry", carry, 1'b1);

    // Scenario 6: idle, reserved op, then reset mid-stream.
    for (int i = 0; i < 3; i++) step(1'b0, 2'b01, 1'b1, 20'h12345, 20'h54321);
    step(1'b1, 2'b11, 1'b1, 20'hFFFFF, 20'hFFFFF);
    step(1'b1, 2'b01, 1'b1, 20'h7FFFF, 20'h00123);
    rst_n = 1'b0;
    step(1'b1, 2'b01, 1'b1, 20'hFFFFF, 20'hFFFFF);
    check("midrst_c", c, 20'h00000);
    rst_n = 1'b1;

    // Mixed random traffic, including half-word ADC chains and upper-bit noise.
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 3) != 0), 2'($urandom), 1'($urandom),
           20'($urandom), 20'($urandom));
    step(1'b1, 2'b01, 1'b0, 20'hFFFFF, 20'h00001);
    step(1'b1, 2'b10, 1'b0, 20'hFFC00, 20'h00000);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_alu_add_and_unit
